bcd_display_feeder: RTL and testbench
=====================================

BCD_DISPLAY_FEEDER -- requirements
Module: bcd_display_feeder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2047: the maximum number of cycles spent in WAIT before the block abandons a conversion.
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 clr  in  1  reset, synchronous and active-high.
REQ-004 value  in  32  unsigned binary value to be displayed.
REQ-005 value_valid  in  1  update request; value SHALL be sampled in every cycle where this is high.
REQ-006 bcd_start  out  1  one-cycle start pulse to the binary-to-BCD converter.
REQ-007 bcd_in  in  32  converter BCD result, low 8 digits, digit 0 in [3:0].
REQ-008 bcd_dv  in  1  converter done pulse; bcd_in is valid while it is high.
REQ-009 disp_word  out  32  8-digit word for the 7-segment display x input.
REQ-010 digit_blank  out  8  per-digit blank mask, bit i=1 blanks digit i.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 update_done  out  1  one-cycle pulse that coincides with the first cycle of new disp_word.
REQ-013 overflow  out  1  high while the displayed value is >= 100_000_000.
REQ-014 timeout_err  out  1  sticky conversion-timeout flag.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, START, WAIT and LATCH; all outputs SHALL be registered.
REQ-016 IDLE: when a request is available (value_valid high or pending set), the block SHALL load the value into cap_reg, clear pending, and branch on the value.
- If cap_reg <= 99_999_999: next state START.
- Otherwise: next state LATCH via the overflow path.
REQ-017 START: bcd_start SHALL be high for exactly this one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-018 WAIT: if bcd_dv is high, the block SHALL capture bcd_in and go to LATCH.
- Otherwise the counter SHALL increment.
- When the counter reaches TIMEOUT_CYCLES, the block SHALL set timeout_err, leave disp_word unchanged and return to IDLE without an update_done pulse.
REQ-019 LATCH, normal path:
- disp_word SHALL take the captured BCD.
- overflow SHALL be 0, timeout_err SHALL clear, update_done SHALL pulse, and the next state SHALL be IDLE.
REQ-020 LATCH, overflow path: disp_word SHALL be 32'hEEEE_EEEE, digit_blank SHALL be 8'h00, overflow SHALL be 1, update_done SHALL pulse, and bcd_start SHALL never assert.
REQ-021 Latency, normal path:
- value_valid sampled in IDLE at cycle 0 SHALL give bcd_start high in cycle 1.
- bcd_dv high in cycle k SHALL give update_done and the new disp_word in cycle k+1.
REQ-022 Latency, overflow path: update_done SHALL be high in cycle 1.
REQ-023 value_valid sampled in START, WAIT or LATCH SHALL store the value in pend_reg and set pending.
- A later request SHALL overwrite an earlier one (latest wins).
- At most one conversion SHALL be queued.
REQ-024 value_valid in the same cycle as LATCH SHALL be queued per REQ-023, and IDLE SHALL start it on the next cycle.
REQ-025 bcd_dv while in IDLE, START or LATCH SHALL be ignored.
REQ-026 bcd_dv and timeout in the same WAIT cycle: bcd_dv SHALL win.
REQ-027 The counter SHALL saturate and SHALL never wrap to zero.
REQ-028 Non-decimal nibbles (A-F) in bcd_in SHALL pass through unaltered.

Reset
REQ-029 While clr is high, the state SHALL be IDLE and the following SHALL be 0: disp_word, digit_blank, busy, bcd_start, update_done, overflow, timeout_err, pending and the counter.
REQ-030 clr asserted mid-conversion SHALL abort the conversion with no update_done pulse.
- A bcd_dv arriving after release SHALL be ignored unless the block is in WAIT.
REQ-031 value_valid in the cycle clr is high SHALL be discarded.

Configuration
REQ-032 Macro BCD_LEADING_ZERO_BLANK_EN.
- Defined: on a normal LATCH, digit_blank[i] SHALL be 1 when digit i and all higher digits are zero, for i = 1..7.
- Defined: digit_blank[0] SHALL always be 0, so value 0 gives 8'hFE.
- Undefined: digit_blank SHALL be constant 8'h00.

Verification
REQ-033 value 12345678 with value_valid for 1 cycle, converter model returning 32'h1234_5678 after 600 cycles -> bcd_start in cycle 1; disp_word=32'h1234_5678; update_done one pulse; digit_blank=8'h00.
REQ-034 value 0, macro defined -> disp_word=0, digit_blank=8'hFE; macro undefined -> digit_blank=8'h00.
REQ-035 value 100_000_000 -> no bcd_start, update_done in cycle 1, disp_word=32'hEEEE_EEEE, overflow=1.
REQ-036 value 5, then values 7 and 9 during WAIT -> exactly two conversions; final disp_word=32'h0000_0009.
REQ-037 converter never asserts bcd_dv -> timeout_err=1 after 2047 WAIT cycles, disp_word unchanged; next good conversion clears timeout_err.
REQ-038 clr pulsed for 1 cycle during WAIT, then bcd_dv -> all outputs 0, no update_done, block idle.

Source files
------------

// File: rtl/bcd_display_feeder_if.sv
// Request and converter handshake for bcd_display_feeder.
// The feeder uses the master modport; the value source and BCD converter use the slave modport.
interface bcd_display_feeder_if;
  logic [31:0] value;
  logic        value_valid;
  logic        bcd_start;
  logic [31:0] bcd_in;
  logic        bcd_dv;

  modport master (
    input  value,
    input  value_valid,
    output bcd_start,
    input  bcd_in,
    input  bcd_dv
  );

  modport slave (
    output value,
    output value_valid,
    input  bcd_start,
    output bcd_in,
    output bcd_dv
  );
endinterface

// File: rtl/bcd_display_feeder.sv
// Feeds an 8-digit 7-segment display from a binary value via an external binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_feeder #(
  parameter int unsigned TIMEOUT_CYCLES = 2047
) (
  input  logic                        clk,
  input  logic                        clr,
  bcd_display_feeder_if.master        bus,
  output logic [31:0]                 disp_word,
  output logic [7:0]                  digit_blank,
  output logic                        busy,
  output logic                        update_done,
  output logic                        overflow,
  output logic                        timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]      MAX_DEC  = 32'd99_999_999;
  localparam logic [31:0]      OVF_WORD = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      disp_word_q, disp_word_d;
  logic [7:0]       digit_blank_q, digit_blank_d;
  logic             busy_q, busy_d;
  logic             bcd_start_q, bcd_start_d;
  logic             update_done_q, update_done_d;
  logic             overflow_q, overflow_d;
  logic             timeout_err_q, timeout_err_d;
  logic [31:0]      req_value;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Digit i blanks when it and every higher digit are zero; digit 0 always shows.
  function automatic logic [7:0] lead_blank(input logic [31:0] bcd);
    logic zero_above;
    lead_blank = 8'h00;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above    = zero_above & (bcd[4*i +: 4] == 4'h0);
      lead_blank[i] = zero_above;
    end
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    pend_val_d    = pend_val_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    disp_word_d   = disp_word_q;
    digit_blank_d = digit_blank_q;
    update_done_d = 1'b0;
    overflow_d    = overflow_q;
    timeout_err_d = timeout_err_q;
    req_value     = bus.value_valid ? bus.value : pend_val_q;

    // A fresh request while busy replaces any queued one.
    if (state_q != IDLE && bus.value_valid) begin
      pend_val_d = bus.value;
      pending_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.value_valid || pending_q) begin
          pending_d = 1'b0;
          if (req_value <= MAX_DEC) begin
            state_d = START;
          end else begin
            state_d       = LATCH;
            disp_word_d   = OVF_WORD;
            digit_blank_d = 8'h00;
            overflow_d    = 1'b1;
            update_done_d = 1'b1;
          end
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.bcd_dv) begin
          state_d       = LATCH;
          disp_word_d   = bus.bcd_in;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          digit_blank_d = lead_blank(bus.bcd_in);
`else
          digit_blank_d = 8'h00;
`endif
          overflow_d    = 1'b0;
          timeout_err_d = 1'b0;
          update_done_d = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_d == CNT_MAX) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      LATCH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    bcd_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      pend_val_q    <= '0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      disp_word_q   <= '0;
      digit_blank_q <= '0;
      busy_q        <= 1'b0;
      bcd_start_q   <= 1'b0;
      update_done_q <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_val_q    <= pend_val_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      disp_word_q   <= disp_word_d;
      digit_blank_q <= digit_blank_d;
      busy_q        <= busy_d;
      bcd_start_q   <= bcd_start_d;
      update_done_q <= update_done_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.bcd_start = bcd_start_q;
  assign disp_word     = disp_word_q;
  assign digit_blank   = digit_blank_q;
  assign busy          = busy_q;
  assign update_done   = update_done_q;
  assign overflow      = overflow_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: directed scenarios plus randomized conversions
// checked against an arithmetic decimal-digit model.
module tb_bcd_display_feeder;
  localparam int TIMEOUT = 2047;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic [31:0] disp_word;
  logic [7:0]  digit_blank;
  logic        busy;
  logic        update_done;
  logic        overflow;
  logic        timeout_err;

  bcd_display_feeder_if bus ();

  bcd_display_feeder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .disp_word   (disp_word),
    .digit_blank (digit_blank),
    .busy        (busy),
    .update_done (update_done),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int upd_cnt = 0;
  logic [31:0] model_disp = 32'h0;

  always @(posedge clk) begin
    if (bus.bcd_start) start_cnt <= start_cnt + 1;
    if (update_done) upd_cnt <= upd_cnt + 1;
  end

  // Decimal digits of v by repeated division, digit 0 in the low nibble.
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    longint x;
    logic [31:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i is blank exactly when the value has fewer than i+1 decimal digits.
  function automatic logic [7:0] exp_blank(input logic [31:0] v);
    logic [7:0] m;
    longint p;
    m = 8'h00;
    p = 10;
    if (BLANK_EN) begin
      for (int i = 1; i < 8; i++) begin
        m[i] = (longint'(v) < p);
        p = p * 10;
      end
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_value(input logic [31:0] v);
    bus.value = v;
    bus.value_valid = 1'b1;
    tick();
    bus.value_valid = 1'b0;
  endtask

  task automatic send_dv(input logic [31:0] b);
    bus.bcd_in = b;
    bus.bcd_dv = 1'b1;
    tick();
    bus.bcd_dv = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.value = 32'd55;
    bus.value_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({disp_word, digit_blank, busy, bus.bcd_start, update_done, overflow, timeout_err} !== 45'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got disp=%h blank=%h busy=%b start=%b upd=%b ovf=%b to=%b, expected all 0",
               disp_word, digit_blank, busy, bus.bcd_start, update_done, overflow, timeout_err);
    end
    bus.value_valid = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_discard: busy got %b, expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int u0;
    u0 = upd_cnt;
    send_value(32'd12345678);
    n_cmp++;
    if (bus.bcd_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_start: got start=%b busy=%b, expected 1 1", bus.bcd_start, busy);
    end
    for (int i = 1; i < 600; i++) tick();
    n_cmp++;
    if (upd_cnt - u0 !== 0 || bus.bcd_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_wait: got updates=%0d start=%b, expected 0 0", upd_cnt - u0, bus.bcd_start);
    end
    send_dv(to_bcd(32'd12345678));
    n_cmp++;
    if (update_done !== 1'b1 || disp_word !== 32'h1234_5678 || digit_blank !== 8'h00 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_latch: got upd=%b disp=%h blank=%h ovf=%b, expected 1 12345678 00 0",
               update_done, disp_word, digit_blank, overflow);
    end
    tick();
    tick();
    n_cmp++;
    if (upd_cnt - u0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_pulse: got updates=%0d busy=%b, expected 1 0", upd_cnt - u0, busy);
    end
    model_disp = 32'h1234_5678;
  endtask

  task automatic test_zero();
    send_value(32'd0);
    tick();
    tick();
    send_dv(to_bcd(32'd0));
    n_cmp++;
    if (disp_word !== 32'h0 || digit_blank !== exp_blank(32'd0) || update_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL zero_latch: got disp=%h blank=%h upd=%b, expected 00000000 %h 1",
               disp_word, digit_blank, update_done, exp_blank(32'd0));
    end
    tick();
    model_disp = 32'h0;
  endtask

  task automatic test_overflow();
    int s0;
    s0 = start_cnt;
    send_value(32'd100_000_000);
    n_cmp++;
    if (update_done !== 1'b1 || bus.bcd_start !== 1'b0 || disp_word !== 32'hEEEE_EEEE ||
        overflow !== 1'b1 || digit_blank !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL ovf_latch: got upd=%b start=%b disp=%h ovf=%b blank=%h, expected 1 0 eeeeeeee 1 00",
               update_done, bus.bcd_start, disp_word, overflow, digit_blank);
    end
    tick();
    tick();
    n_cmp++;
    if (start_cnt - s0 !== 0 || busy !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_after: got starts=%0d busy=%b ovf=%b, expected 0 0 1", start_cnt - s0, busy, overflow);
    end
    send_value(32'd99_999_999);
    n_cmp++;
    if (bus.bcd_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL max_dec_start: got %b, expected 1", bus.bcd_start);
    end
    tick();
    send_dv(to_bcd(32'd99_999_999));
    n_cmp++;
    if (disp_word !== 32'h9999_9999 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_dec_latch: got disp=%h ovf=%b, expected 99999999 0", disp_word, overflow);
    end
    tick();
    model_disp = 32'h9999_9999;
  endtask

  task automatic test_nondecimal();
    logic [7:0] eb;
    eb = BLANK_EN ? 8'hC0 : 8'h00;
    send_value(32'd1234);
    tick();
    send_dv(32'h00AB_CDEF);
    n_cmp++;
    if (disp_word !== 32'h00AB_CDEF || digit_blank !== eb) begin
      n_fail++;
      $display("[TB] FAIL nondec: got disp=%h blank=%h, expected 00abcdef %h", disp_word, digit_blank, eb);
    end
    tick();
    model_disp = 32'h00AB_CDEF;
  endtask

  task automatic test_back_to_back();
    int s0;
    bit found;
    s0 = start_cnt;
    send_value(32'd5);
    tick();
    send_value(32'd7);
    send_value(32'd9);
    send_dv(to_bcd(32'd5));
    n_cmp++;
    if (disp_word !== 32'h5 || update_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL queue_first: got disp=%h upd=%b, expected 00000005 1", disp_word, update_done);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.bcd_start === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL queue_restart: got no bcd_start within 10 cycles, expected one");
    end
    tick();
    send_dv(to_bcd(32'd9));
    n_cmp++;
    if (disp_word !== 32'h9) begin
      n_fail++;
      $display("[TB] FAIL queue_final: got %h, expected 00000009", disp_word);
    end
    repeat (10) tick();
    n_cmp++;
    if (start_cnt - s0 !== 2) begin
      n_fail++;
      $display("[TB] FAIL queue_count: got %0d conversions, expected 2", start_cnt - s0);
    end
    // A request arriving during LATCH must start on the cycle after the following IDLE.
    send_value(32'd21);
    tick();
    send_dv(to_bcd(32'd21));
    send_value(32'd22);
    tick();
    n_cmp++;
    if (bus.bcd_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL latch_queue_start: got %b, expected 1", bus.bcd_start);
    end
    tick();
    send_dv(to_bcd(32'd22));
    n_cmp++;
    if (disp_word !== 32'h22) begin
      n_fail++;
      $display("[TB] FAIL latch_queue_disp: got %h, expected 00000022", disp_word);
    end
    tick();
    model_disp = 32'h22;
  endtask

  task automatic test_timeout();
    int u0;
    int n;
    u0 = upd_cnt;
    send_value(32'd42);
    n = 0;
    while (timeout_err !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== TIMEOUT + 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after start, expected %0d", n, TIMEOUT + 1);
    end
    n_cmp++;
    if (disp_word !== model_disp || busy !== 1'b0 || upd_cnt - u0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_state: got disp=%h busy=%b updates=%0d, expected %h 0 0",
               disp_word, busy, upd_cnt - u0, model_disp);
    end
    send_value(32'd77);
    tick();
    tick();
    send_dv(to_bcd(32'd77));
    n_cmp++;
    if (timeout_err !== 1'b0 || disp_word !== 32'h77) begin
      n_fail++;
      $display("[TB] FAIL timeout_clear: got to=%b disp=%h, expected 0 00000077", timeout_err, disp_word);
    end
    tick();
    model_disp = 32'h77;
  endtask

  task automatic test_dv_timeout_race();
    send_value(32'd31);
    repeat (TIMEOUT) tick();
    send_dv(to_bcd(32'd31));
    n_cmp++;
    if (update_done !== 1'b1 || disp_word !== 32'h31 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL race: got upd=%b disp=%h to=%b, expected 1 00000031 0", update_done, disp_word, timeout_err);
    end
    tick();
    model_disp = 32'h31;
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] exp_disp;
    logic [7:0]  exp_bl;
    bit          exp_ovf;
    int          d;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_dv($urandom);
        n_cmp++;
        if (disp_word !== model_disp || update_done !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rnd_idle_dv: got disp=%h upd=%b busy=%b, expected %h 0 0",
                   disp_word, update_done, busy, model_disp);
        end
      end
      if ($urandom_range(0, 3) == 0) v = 32'd100_000_000 + $urandom_range(0, 32'hF000_0000);
      else v = $urandom_range(0, 99_999_999);
      exp_ovf  = (v >= 32'd100_000_000);
      exp_disp = exp_ovf ? 32'hEEEE_EEEE : to_bcd(v);
      exp_bl   = exp_ovf ? 8'h00 : exp_blank(v);
      send_value(v);
      if (!exp_ovf) begin
        d = $urandom_range(1, 30);
        repeat (d) tick();
        send_dv(to_bcd(v));
      end
      n_cmp++;
      if (disp_word !== exp_disp || digit_blank !== exp_bl || overflow !== exp_ovf ||
          update_done !== 1'b1 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rnd_latch v=%0d: got disp=%h blank=%h ovf=%b upd=%b to=%b, expected %h %h %b 1 0",
                 v, disp_word, digit_blank, overflow, update_done, timeout_err, exp_disp, exp_bl, exp_ovf);
      end
      tick();
      model_disp = exp_disp;
    end
  endtask

  task automatic test_clr_mid();
    int s0;
    int u0;
    send_value(32'd12);
    tick();
    tick();
    u0 = upd_cnt;
    clr = 1'b1;
    bus.value = 32'd3;
    bus.value_valid = 1'b1;
    tick();
    clr = 1'b0;
    bus.value_valid = 1'b0;
    s0 = start_cnt;
    send_dv(to_bcd(32'd12));
    n_cmp++;
    if ({disp_word, digit_blank, busy, bus.bcd_start, update_done, overflow, timeout_err} !== 45'h0) begin
      n_fail++;
      $display("[TB] FAIL clr_mid: got disp=%h blank=%h busy=%b start=%b upd=%b ovf=%b to=%b, expected all 0",
               disp_word, digit_blank, busy, bus.bcd_start, update_done, overflow, timeout_err);
    end
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b0 || start_cnt - s0 !== 0 || upd_cnt - u0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL clr_idle: got busy=%b starts=%0d updates=%0d, expected 0 0 0",
               busy, start_cnt - s0, upd_cnt - u0);
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.value = '0;
    bus.value_valid = 1'b0;
    bus.bcd_in = '0;
    bus.bcd_dv = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_nondecimal();
    test_back_to_back();
    test_timeout();
    test_dv_timeout_race();
    test_random();
    test_clr_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
